// File: rtl/multi_accum_pkg.sv
// Shared definitions for the multi-channel accumulator.
//   state_e  : clear-all sequencer states
//   ch_width : channel-index width for a given channel count (never below 1)
package multi_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_e;

    // Channel index width: clog2 of the channel count, minimum one bit
    function automatic int ch_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational accumulate step with wrap or saturate behaviour.
// Ports:
//   acc      : current accumulator value
//   data     : unsigned sample, zero-extended before the add
//   sat_en   : 1 = clamp to all ones on carry-out, 0 = keep the low bits
//   acc_next : value to write back
//   ovf      : carry-out of the add (overflow in either mode)
module accum_sat_add
    import multi_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    input  logic              sat_en,
    output logic [ACC_W-1:0]  acc_next,
    output logic              ovf
);

    logic [ACC_W:0] sum_s;

    // One extra bit of sum width exposes the carry used for overflow
    always_comb begin
        sum_s = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, data};
        if (sum_s[ACC_W]) begin
            ovf = 1'b1;
            if (sat_en) begin
                acc_next = {ACC_W{1'b1}};
            end else begin
                acc_next = sum_s[ACC_W-1:0];
            end
        end else begin
            ovf      = 1'b0;
            acc_next = sum_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/multi_accum.sv
// Multi-channel running-sum accumulator.
// Ports:
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      : sample handshake; in_chan/in_data/sat_en travel with it
//   clr_valid/clr_chan     : clear one channel (IDLE only)
//   clr_all                : start a drain + sweep that clears every channel
//   rd_req/rd_chan         : read request; rd_valid/rd_data/rd_ovf one edge later
//   ovf_flags              : sticky per-channel overflow flags
// A sample is registered into S1 on accept and written back on the next edge,
// so a following sample to the same channel already sees the updated value.
module multi_accum
    import multi_accum_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 32,
    parameter int CHANNELS = 4,
    localparam int CH_W    = ch_width(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_chan,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                sat_en,
    input  logic                clr_valid,
    input  logic [CH_W-1:0]     clr_chan,
    input  logic                clr_all,
    input  logic                rd_req,
    input  logic [CH_W-1:0]     rd_chan,
    output logic                rd_valid,
    output logic [ACC_W-1:0]    rd_data,
    output logic                rd_ovf,
    output logic [CHANNELS-1:0] ovf_flags
);

    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

    state_e                state_r, next_state_s;
    logic [CH_W-1:0]       idx_r;
    logic                  in_ready_r;
    logic                  s1_valid_r;
    logic [CH_W-1:0]       s1_chan_r;
    logic [DATA_W-1:0]     s1_data_r;
    logic                  s1_sat_r;
    logic [ACC_W-1:0]      acc_r [CHANNELS];
    logic [CHANNELS-1:0]   ovf_r;
    logic                  rd_valid_r;
    logic [ACC_W-1:0]      rd_data_r;
    logic                  rd_ovf_r;

    logic                  idle_s, sweep_s;
    logic                  accept_s, in_ok_s, clr_ok_s, rd_ok_s;
    logic                  clr_do_s, clr_hit_s;
    logic [ACC_W-1:0]      add_in_s, add_next_s;
    logic                  add_ovf_s;

    assign in_ready  = in_ready_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_ovf    = rd_ovf_r;
    assign ovf_flags = ovf_r;

    // FSM state register and sweep index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            idx_r      <= {CH_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s == IDLE);
            if (state_r == DRAIN) begin
                idx_r <= {CH_W{1'b0}};
            end else if (state_r == SWEEP) begin
                idx_r <= idx_r + {{(CH_W-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr_all) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAIN: next_state_s = SWEEP;
            SWEEP: begin
                if (idx_r == LAST_CH) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SWEEP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state decodes
    always_comb begin
        idle_s  = 1'b0;
        sweep_s = 1'b0;
        case (state_r)
            IDLE:    idle_s  = 1'b1;
            SWEEP:   sweep_s = 1'b1;
            default: idle_s  = 1'b0;
        endcase
    end

    // Handshake, range checks and clear/S1 collision detection
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        in_ok_s   = ({1'b0, in_chan}  < CH_LIMIT);
        clr_ok_s  = ({1'b0, clr_chan} < CH_LIMIT);
        rd_ok_s   = ({1'b0, rd_chan}  < CH_LIMIT);
        clr_do_s  = clr_valid && idle_s && clr_ok_s;
        clr_hit_s = clr_do_s && s1_valid_r && (clr_chan == s1_chan_r);
        // Clear-then-add: a colliding clear makes the add start from zero
        if (clr_hit_s) begin
            add_in_s = {ACC_W{1'b0}};
        end else begin
            add_in_s = acc_r[s1_chan_r];
        end
    end

    accum_sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc      (add_in_s),
        .data     (s1_data_r),
        .sat_en   (s1_sat_r),
        .acc_next (add_next_s),
        .ovf      (add_ovf_s)
    );

    // S1 stage: out-of-range samples are accepted but never become valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_chan_r  <= {CH_W{1'b0}};
            s1_data_r  <= {DATA_W{1'b0}};
            s1_sat_r   <= 1'b0;
        end else begin
            s1_valid_r <= accept_s && in_ok_s;
            if (accept_s) begin
                s1_chan_r <= in_chan;
                s1_data_r <= in_data;
                s1_sat_r  <= sat_en;
            end else begin
                s1_chan_r <= s1_chan_r;
                s1_data_r <= s1_data_r;
                s1_sat_r  <= s1_sat_r;
            end
        end
    end

    // Channel storage: sweep clear, then S1 write-back, then single clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
            ovf_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sweep_s && (idx_r == CH_W'(i))) begin
                    acc_r[i] <= {ACC_W{1'b0}};
                    ovf_r[i] <= 1'b0;
                end else if (s1_valid_r && (s1_chan_r == CH_W'(i))) begin
                    acc_r[i] <= add_next_s;
                    ovf_r[i] <= add_ovf_s | (ovf_r[i] & ~clr_hit_s);
                end else if (clr_do_s && (clr_chan == CH_W'(i))) begin
                    acc_r[i] <= {ACC_W{1'b0}};
                    ovf_r[i] <= 1'b0;
                end else begin
                    acc_r[i] <= acc_r[i];
                    ovf_r[i] <= ovf_r[i];
                end
            end
        end
    end

    // Registered read port returning pre-edge storage contents
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {ACC_W{1'b0}};
            rd_ovf_r   <= 1'b0;
        end else begin
            rd_valid_r <= rd_req;
            if (rd_req && rd_ok_s) begin
                rd_data_r <= acc_r[rd_chan];
                rd_ovf_r  <= ovf_r[rd_chan];
            end else begin
                rd_data_r <= {ACC_W{1'b0}};
                rd_ovf_r  <= 1'b0;
            end
        end
    end

endmodule
